// File: rtl/morph_pkg.sv
// rtl/morph_pkg.sv - shared state encoding and default image size for the 3x3 morphology blocks
package morph_pkg;

    localparam int IMG_W_DEFAULT = 28;
    localparam int IMG_H_DEFAULT = 28;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } morph_state_t;

endpackage

// File: rtl/morph_line_buffer.sv
// rtl/morph_line_buffer.sv - one image row of 1-bit pixels as an enabled shift register
module morph_line_buffer
    import morph_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_din,
    output logic o_dout
);

    logic [DEPTH-1:0] r_shift;

    // Shift in one pixel per enable; the output is the pixel taken DEPTH enables ago.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
        end else if (i_en) begin
            r_shift <= {r_shift[DEPTH-2:0], i_din};
        end
    end

    assign o_dout = r_shift[DEPTH-1];

endmodule

// File: rtl/binary_erode_3x3.sv
// rtl/binary_erode_3x3.sv - streaming 3x3 binary erosion, one pixel per clock
module binary_erode_3x3
    import morph_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic pixelIn,
    input  logic pixelValid,
    input  logic pixelSof,
    output logic inReady,
    output logic pixelOut,
    output logic outValid,
    output logic outSof,
    output logic outEof
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 1);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
    localparam logic [FW-1:0] F_LAST = FW'(IMG_W);

    morph_state_t  r_state, w_state_nxt;
    logic [CW-1:0] r_col, w_col_nxt;
    logic [RW-1:0] r_row, w_row_nxt;
    logic [FW-1:0] r_flush, w_flush_nxt;
    logic [1:0]    r_win_top, r_win_mid, r_win_bot;
    logic          r_in_ready, r_pix, r_valid, r_sof, r_eof;
    logic          w_accept, w_top, w_mid, w_and, w_border;
    logic          w_valid_nxt, w_pix_nxt, w_sof_nxt, w_eof_nxt;

    assign w_accept = pixelValid & r_in_ready;

    morph_line_buffer #(.DEPTH(IMG_W)) u_lb_mid (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_accept),
        .i_din  (pixelIn),
        .o_dout (w_mid)
    );

    morph_line_buffer #(.DEPTH(IMG_W)) u_lb_top (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_accept),
        .i_din  (w_mid),
        .o_dout (w_top)
    );

    // Window after this pixel: two stored columns plus the incoming column (rows r-2, r-1, r).
    assign w_and = &{r_win_top, r_win_mid, r_win_bot, w_top, w_mid, pixelIn};

    // Centre is (r_row-1, r_col-1); col 0 wraps to the last column of the row above, so
    // c<=1 covers both left and right borders and r_row==1 covers the top row.
    assign w_border = (r_col <= CW'(1)) | (r_row == RW'(1));

    // Next-state, counters and output pixel decode.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_flush_nxt = r_flush;
        w_valid_nxt = 1'b0;
        w_pix_nxt   = 1'b0;
        w_sof_nxt   = 1'b0;
        w_eof_nxt   = 1'b0;
        case (r_state)
            ST_IDLE, ST_FILL, ST_RUN: begin
                if (w_accept) begin
                    if (pixelSof) begin
                        // Start (or restart) a frame: this pixel is k=0.
                        w_state_nxt = ST_FILL;
                        w_col_nxt   = CW'(1);
                        w_row_nxt   = '0;
                    end else if (r_state != ST_IDLE) begin
                        if (r_col == C_LAST) begin
                            w_col_nxt = '0;
                            w_row_nxt = r_row + 1'b1;
                        end else begin
                            w_col_nxt = r_col + 1'b1;
                        end
                        if (r_state == ST_FILL) begin
                            if ((r_row == RW'(1)) && (r_col == '0)) begin
                                w_state_nxt = ST_RUN;
                            end
                        end else begin
                            w_valid_nxt = 1'b1;
                            w_pix_nxt   = w_and & ~w_border;
                            w_sof_nxt   = (r_row == RW'(1)) && (r_col == CW'(1));
                            if ((r_row == R_LAST) && (r_col == C_LAST)) begin
                                w_state_nxt = ST_FLUSH;
                                w_flush_nxt = '0;
                            end
                        end
                    end
                end
            end
            ST_FLUSH: begin
                // Remaining centres lie on the bottom row or its left neighbour: all zero.
                w_valid_nxt = 1'b1;
                if (r_flush == F_LAST) begin
                    w_eof_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                end else begin
                    w_flush_nxt = r_flush + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs; inReady is a decode of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_flush    <= '0;
            r_in_ready <= 1'b1;
            r_valid    <= 1'b0;
            r_pix      <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_flush    <= w_flush_nxt;
            r_in_ready <= (w_state_nxt != ST_FLUSH);
            r_valid    <= w_valid_nxt;
            r_pix      <= w_pix_nxt;
            r_sof      <= w_sof_nxt;
            r_eof      <= w_eof_nxt;
        end
    end

    // Keep the two previous columns of the 3-row window, advancing only on accepted pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_top <= '0;
            r_win_mid <= '0;
            r_win_bot <= '0;
        end else if (w_accept) begin
            r_win_top <= {r_win_top[0], w_top};
            r_win_mid <= {r_win_mid[0], w_mid};
            r_win_bot <= {r_win_bot[0], pixelIn};
        end
    end

    assign inReady  = r_in_ready;
    assign pixelOut = r_pix;
    assign outValid = r_valid;
    assign outSof   = r_sof;
    assign outEof   = r_eof;

endmodule

// File: tb/tb_binary_erode_3x3.sv
// tb/tb_binary_erode_3x3.sv - self-checking bench for binary_erode_3x3 (28x28 and 8x5)
module tb_binary_erode_3x3;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int N  = W * H;
    localparam int W2 = 8;
    localparam int H2 = 5;
    localparam int N2 = W2 * H2;

    typedef struct {
        int r0, c0, hh, ww;
        int duty;
        int exp_ones;
        int exp_first;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic a_pin, a_pvalid, a_psof, a_ready, a_pout, a_ovalid, a_osof, a_oeof;
    logic b_pin, b_pvalid, b_psof, b_ready, b_pout, b_ovalid, b_osof, b_oeof;

    binary_erode_3x3 #(.IMG_W(W), .IMG_H(H)) u_dut_a (
        .clk(clk), .reset(reset), .pixelIn(a_pin), .pixelValid(a_pvalid), .pixelSof(a_psof),
        .inReady(a_ready), .pixelOut(a_pout), .outValid(a_ovalid), .outSof(a_osof), .outEof(a_oeof)
    );

    binary_erode_3x3 #(.IMG_W(W2), .IMG_H(H2)) u_dut_b (
        .clk(clk), .reset(reset), .pixelIn(b_pin), .pixelValid(b_pvalid), .pixelSof(b_psof),
        .inReady(b_ready), .pixelOut(b_pout), .outValid(b_ovalid), .outSof(b_osof), .outEof(b_oeof)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [2:0] q_a[$];
    logic [2:0] q_b[$];
    int acc_a = 0, acc_b = 0;
    int first_acc_a = -1, first_acc_b = -1;
    int low_run_a = 0, last_low_a = -1, low_run_b = 0, last_low_b = -1;
    int stray = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Output capture and inReady low-run measurement, sampled on the falling edge.
    always @(negedge clk) begin
        if (a_ovalid) begin
            if (q_a.size() == 0) first_acc_a = acc_a;
            q_a.push_back({a_pout, a_osof, a_oeof});
        end else if (a_osof || a_oeof || a_pout) stray++;
        if (b_ovalid) begin
            if (q_b.size() == 0) first_acc_b = acc_b;
            q_b.push_back({b_pout, b_osof, b_oeof});
        end else if (b_osof || b_oeof || b_pout) stray++;
        if (!a_ready) low_run_a++;
        else begin
            if (low_run_a != 0) last_low_a = low_run_a;
            low_run_a = 0;
        end
        if (!b_ready) low_run_b++;
        else begin
            if (low_run_b != 0) last_low_b = low_run_b;
            low_run_b = 0;
        end
    end

    function automatic bit ref_px(input bit img[], input int w, input int h, input int r, input int c);
        if (r == 0 || c == 0 || r == h - 1 || c == w - 1) return 1'b0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!img[(r + dr) * w + c + dc]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic make_rect(output bit img[], input int w, input int h,
                             input int r0, input int c0, input int hh, input int ww);
        img = new[w * h];
        for (int i = 0; i < w * h; i++)
            img[i] = ((i / w) >= r0) && ((i / w) < r0 + hh) && ((i % w) >= c0) && ((i % w) < c0 + ww);
    endtask

    task automatic make_rand(output bit img[], input int w, input int h);
        img = new[w * h];
        for (int i = 0; i < w * h; i++) img[i] = ($urandom_range(9) < 8);
    endtask

    task automatic drive(input int which, input bit img[], input int n, input int duty, input bit with_sof);
        bit v, rdy, done;
        int guard;
        for (int k = 0; k < n; k++) begin
            done = 1'b0;
            guard = 0;
            while (!done) begin
                @(negedge clk);
                v = (int'($urandom_range(99)) < duty);
                if (which == 0) begin
                    a_pvalid = v; a_pin = img[k]; a_psof = with_sof && (k == 0); rdy = a_ready;
                end else begin
                    b_pvalid = v; b_pin = img[k]; b_psof = with_sof && (k == 0); rdy = b_ready;
                end
                @(posedge clk);
                if (v && rdy) begin
                    done = 1'b1;
                    if (which == 0) acc_a = (with_sof && k == 0) ? 1 : acc_a + 1;
                    else            acc_b = (with_sof && k == 0) ? 1 : acc_b + 1;
                end
                guard++;
                if (!done && guard >= 2000) begin
                    chk("drive_timeout", 0, 1);
                    return;
                end
            end
        end
    endtask

    task automatic idle(input int which);
        @(negedge clk);
        if (which == 0) begin a_pvalid = 1'b0; a_psof = 1'b0; end
        else            begin b_pvalid = 1'b0; b_psof = 1'b0; end
    endtask

    task automatic wait_out(input int which, input int n, input int budget);
        int i;
        i = 0;
        while ((((which == 0) ? q_a.size() : q_b.size()) < n) && (i < budget)) begin
            @(negedge clk);
            i++;
        end
        if (i >= budget) chk("wait_out_timeout", 0, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic analyze(input int which, input int base, input bit img[], input int w, input int h,
                           output int ones, output int first_one, output int sof_pos,
                           output int eof_pos, output int mism);
        logic [2:0] e;
        int total, j;
        total = (which == 0) ? q_a.size() : q_b.size();
        ones = 0; first_one = -1; sof_pos = -1; eof_pos = -1; mism = 0;
        for (int i = base; i < total && i < base + w * h; i++) begin
            e = (which == 0) ? q_a[i] : q_b[i];
            j = i - base;
            if (e[2]) begin ones++; if (first_one < 0) first_one = j; end
            if (e[1] && sof_pos < 0) sof_pos = j;
            if (e[0] && eof_pos < 0) eof_pos = j;
            if (e[2] != ref_px(img, w, h, j / w, j % w)) mism++;
        end
    endtask

    vec_t vecs[6];
    bit img1[], img2[];
    int ones, first_one, sof_pos, eof_pos, mism, n_before, eofs, sofs;

    initial begin
        vecs[0] = '{0, 0, 28, 28, 100, 676, 29};
        vecs[1] = '{10, 10, 3, 3, 100, 1, 319};
        vecs[2] = '{10, 10, 2, 3, 100, 0, -1};
        vecs[3] = '{0, 0, 28, 28, 50, 676, 29};
        vecs[4] = '{5, 20, 4, 5, 100, 6, 189};
        vecs[5] = '{0, 0, 4, 4, 100, 4, 29};

        reset = 1'b1;
        a_pin = 0; a_pvalid = 0; a_psof = 0;
        b_pin = 0; b_pvalid = 0; b_psof = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_inReady", int'(a_ready), 1);
        chk("rst_outValid", int'(a_ovalid), 0);
        chk("rst_outSof", int'(a_osof), 0);
        chk("rst_outEof", int'(a_oeof), 0);
        chk("rst_pixelOut", int'(a_pout), 0);
        reset = 1'b0;

        // Table-driven single frames on the 28x28 instance.
        for (int t = 0; t < 6; t++) begin
            make_rect(img1, W, H, vecs[t].r0, vecs[t].c0, vecs[t].hh, vecs[t].ww);
            q_a.delete(); first_acc_a = -1; last_low_a = -1;
            drive(0, img1, N, vecs[t].duty, 1'b1);
            idle(0);
            wait_out(0, N, 200);
            analyze(0, 0, img1, W, H, ones, first_one, sof_pos, eof_pos, mism);
            chk($sformatf("t%0d_count", t), q_a.size(), N);
            chk($sformatf("t%0d_ones", t), ones, vecs[t].exp_ones);
            chk($sformatf("t%0d_first_one", t), first_one, vecs[t].exp_first);
            chk($sformatf("t%0d_sof_pos", t), sof_pos, 0);
            chk($sformatf("t%0d_eof_pos", t), eof_pos, N - 1);
            chk($sformatf("t%0d_ref_mism", t), mism, 0);
            chk($sformatf("t%0d_first_latency", t), first_acc_a, W + 2);
            chk($sformatf("t%0d_ready_low", t), last_low_a, W + 1);
        end

        // Resync: abort after 300 pixels, then a full frame.
        make_rect(img1, W, H, 0, 0, H, W);
        q_a.delete();
        drive(0, img1, 300, 100, 1'b1);
        drive(0, img1, N, 100, 1'b1);
        idle(0);
        wait_out(0, 271 + N, 200);
        chk("resync_count", q_a.size(), 271 + N);
        eofs = 0; sofs = 0;
        foreach (q_a[i]) begin
            if (q_a[i][0]) eofs++;
            if (q_a[i][1]) sofs++;
        end
        chk("resync_eof_total", eofs, 1);
        chk("resync_sof_total", sofs, 2);
        analyze(0, 271, img1, W, H, ones, first_one, sof_pos, eof_pos, mism);
        chk("resync_sof_pos", sof_pos, 0);
        chk("resync_eof_pos", eof_pos, N - 1);
        chk("resync_mism", mism, 0);

        // Reset mid-RUN, then pixels without pixelSof must be dropped.
        q_a.delete();
        drive(0, img1, 400, 100, 1'b1);
        @(negedge clk);
        a_pvalid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_outValid", int'(a_ovalid), 0);
        chk("midrst_inReady", int'(a_ready), 1);
        reset = 1'b0;
        n_before = q_a.size();
        drive(0, img1, 100, 100, 1'b0);
        idle(0);
        repeat (40) @(negedge clk);
        chk("midrst_no_output", q_a.size(), n_before);

        // Back-to-back frames with pixelValid held high through FLUSH, 28x28.
        make_rand(img1, W, H);
        make_rand(img2, W, H);
        q_a.delete(); last_low_a = -1;
        drive(0, img1, N, 100, 1'b1);
        drive(0, img2, N, 100, 1'b1);
        idle(0);
        wait_out(0, 2 * N, 200);
        chk("b2b_a_count", q_a.size(), 2 * N);
        analyze(0, 0, img1, W, H, ones, first_one, sof_pos, eof_pos, mism);
        chk("b2b_a_f1_mism", mism, 0);
        chk("b2b_a_f1_eof", eof_pos, N - 1);
        analyze(0, N, img2, W, H, ones, first_one, sof_pos, eof_pos, mism);
        chk("b2b_a_f2_sof", sof_pos, 0);
        chk("b2b_a_f2_eof", eof_pos, N - 1);
        chk("b2b_a_f2_mism", mism, 0);
        chk("b2b_a_ready_low", last_low_a, W + 1);

        // Back-to-back on the 8x5 instance: all-ones frame then a random frame.
        make_rect(img1, W2, H2, 0, 0, H2, W2);
        make_rand(img2, W2, H2);
        q_b.delete(); first_acc_b = -1; last_low_b = -1;
        drive(1, img1, N2, 100, 1'b1);
        drive(1, img2, N2, 100, 1'b1);
        idle(1);
        wait_out(1, 2 * N2, 200);
        chk("b2b_b_count", q_b.size(), 2 * N2);
        analyze(1, 0, img1, W2, H2, ones, first_one, sof_pos, eof_pos, mism);
        chk("b2b_b_f1_ones", ones, 18);
        chk("b2b_b_f1_first_one", first_one, 9);
        chk("b2b_b_f1_mism", mism, 0);
        chk("b2b_b_f1_eof", eof_pos, N2 - 1);
        analyze(1, N2, img2, W2, H2, ones, first_one, sof_pos, eof_pos, mism);
        chk("b2b_b_f2_sof", sof_pos, 0);
        chk("b2b_b_f2_eof", eof_pos, N2 - 1);
        chk("b2b_b_f2_mism", mism, 0);
        chk("b2b_b_first_latency", first_acc_b, W2 + 2);
        chk("b2b_b_ready_low", last_low_b, W2 + 1);

        chk("stray_flags", stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
